// File: rtl/y_window_pkg.sv
// Shared definitions for the vertical/horizontal window FIRs: accumulator sizing,
// coefficient rotation and rounding helpers, plus the commit FSM state type.
package y_window_pkg;

    typedef enum logic {
        COMMIT_IDLE,
        COMMIT_PENDING
    } commit_state_t;

    localparam int ROUND_SHIFT_DEFAULT = 8;
    localparam int ROUND_CONST_DEFAULT = 1 << (ROUND_SHIFT_DEFAULT - 1);

    function automatic int acc_width(int data_w, int coef_w, int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Base coefficient index for row j given the line-buffer rotation; out-of-range rotation means none.
    function automatic int rot_idx(int j, int hsel, int taps);
        int h;
        h = (hsel >= taps) ? 0 : hsel;
        return (j - h + taps) % taps;
    endfunction

    function automatic int round_const(int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/pipe_adder_tree.sv
// Stallable registered pairwise-sum tree: one register level per halving, each level
// carrying its own valid bit; all levels advance together when en is high.
module pipe_adder_tree #(
    parameter int N = 5,
    parameter int W = 19
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N*W-1:0]         din,
    input  logic                   in_valid,
    output logic [W-1:0]           dout,
    output logic                   out_valid,
    output logic [$clog2(N)-1:0]   level_valid
);

    localparam int LEVELS = $clog2(N);

    function automatic int level_cnt(int k);
        return (N + (1 << k) - 1) >> k;
    endfunction

    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
        localparam int CNT = level_cnt(lv);
        logic [CNT*W-1:0] node;
        logic             vld;

        if (lv == 0) begin : g_in
            assign node = din;
            assign vld  = in_valid;
        end else begin : g_reg
            localparam int PCNT = level_cnt(lv - 1);
            localparam int PW   = 2 * CNT * W;
            // Zero padding turns the odd leftover element into a plain pass-through.
            logic [PW-1:0] prev_pad;

            assign prev_pad = PW'(g_lvl[lv-1].node);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    node <= '0;
                    vld  <= 1'b0;
                end else if (en) begin
                    for (int i = 0; i < CNT; i++) begin
                        node[i*W +: W] <= prev_pad[2*i*W +: W] + prev_pad[(2*i+1)*W +: W];
                    end
                    vld <= g_lvl[lv-1].vld;
                end
            end

            assign level_valid[lv-1] = vld;
        end
    end

    assign dout      = g_lvl[LEVELS].node;
    assign out_valid = g_lvl[LEVELS].vld;

endmodule

// File: rtl/y_window_fir.sv
// Vertical window FIR: rotated coefficient multiply, pipelined adder tree, round and
// saturate, with valid/ready backpressure and a drain-then-copy coefficient commit.
//
// state          | meaning
// COMMIT_IDLE    | active bank in use, shadow writes allowed, samples admitted
// COMMIT_PENDING | commit requested; input blocked until pipeline empty, then shadow -> active
module y_window_fir
    import y_window_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int SHIFT  = 8,
    parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {8'd6, 8'd58, 8'd128, 8'd58, 8'd6}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [TAPS*DATA_W-1:0]     din,
    input  logic [$clog2(TAPS)-1:0]    hsel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       coef_wr,
    input  logic [$clog2(TAPS)-1:0]    coef_idx,
    input  logic [COEF_W-1:0]          coef_data,
    input  logic                       coef_commit,
    output logic                       coef_busy
);

    localparam int A     = $clog2(TAPS);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam logic [ACC_W:0] ROUND_K = (ACC_W + 1)'(round_const(SHIFT));
    localparam logic [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << DATA_W) - 1);

    commit_state_t state_q, state_d;
    logic          copy_en;

    logic                     advance;
    logic                     accept;
    logic                     pipe_busy;
    logic [TAPS*COEF_W-1:0]   base_q;
    logic [TAPS*COEF_W-1:0]   shadow_q;
    logic [TAPS*ACC_W-1:0]    prod_d;
    logic [TAPS*ACC_W-1:0]    prod_q;
    logic                     v1_q;
    logic [ACC_W-1:0]         tree_sum;
    logic                     tree_valid;
    logic [A-1:0]             tree_lvl_valid;
    logic [ACC_W:0]           rounded;

    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance & (state_q == COMMIT_IDLE);
    assign accept    = in_valid & in_ready;
    assign coef_busy = (state_q == COMMIT_PENDING);
    assign pipe_busy = v1_q | (|tree_lvl_valid) | out_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= COMMIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        copy_en = 1'b0;
        case (state_q)
            COMMIT_IDLE: begin
                if (coef_commit) begin
                    state_d = COMMIT_PENDING;
                end
            end
            COMMIT_PENDING: begin
                if (!pipe_busy) begin
                    copy_en = 1'b1;
                    state_d = COMMIT_IDLE;
                end
            end
            default: state_d = COMMIT_IDLE;
        endcase
    end

    // Nonblocking copy means a same-cycle shadow write lands after the copy samples shadow_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q   <= COEF_INIT;
            shadow_q <= COEF_INIT;
        end else begin
            if (copy_en) begin
                base_q <= shadow_q;
            end
            if (coef_wr && (int'(coef_idx) < TAPS)) begin
                shadow_q[int'(coef_idx)*COEF_W +: COEF_W] <= coef_data;
            end
        end
    end

    always_comb begin
        prod_d = '0;
        for (int j = 0; j < TAPS; j++) begin
            prod_d[j*ACC_W +: ACC_W] =
                ACC_W'(din[j*DATA_W +: DATA_W]) *
                ACC_W'(base_q[rot_idx(j, int'(hsel), TAPS)*COEF_W +: COEF_W]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q   <= 1'b0;
            prod_q <= '0;
        end else if (advance) begin
            v1_q   <= accept;
            prod_q <= prod_d;
        end
    end

    pipe_adder_tree #(
        .N (TAPS),
        .W (ACC_W)
    ) u_tree (
        .clock       (clock),
        .reset       (reset),
        .en          (advance),
        .din         (prod_q),
        .in_valid    (v1_q),
        .dout        (tree_sum),
        .out_valid   (tree_valid),
        .level_valid (tree_lvl_valid)
    );

    assign rounded = ({1'b0, tree_sum} + ROUND_K) >> SHIFT;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= tree_valid;
            dout      <= (rounded > PIX_MAX) ? '1 : rounded[DATA_W-1:0];
        end
    end

endmodule
